// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the write-back arbiter's request and result signals.
//   ALU side    : alu_valid, alu_reg[3:0], alu_data[15:0] -> alu_stall
//   Load side   : ld_valid, ld_reg[3:0], ld_data[15:0]    -> ld_ready
//   Register file: WriteReg, DstReg[3:0], DstData[15:0]
//   Hazard mask : ld_pending[15:0]
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface wb_arbiter_if;
   logic        alu_valid;
   logic [3:0]  alu_reg;
   logic [15:0] alu_data;
   logic        alu_stall;
   logic        ld_valid;
   logic        ld_ready;
   logic [3:0]  ld_reg;
   logic [15:0] ld_data;
   logic        WriteReg;
   logic [3:0]  DstReg;
   logic [15:0] DstData;
   logic [15:0] ld_pending;

   modport slave (
      input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
      output alu_stall, ld_ready, WriteReg, DstReg, DstData, ld_pending
   );

   modport master (
      output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
      input  alu_stall, ld_ready, WriteReg, DstReg, DstData, ld_pending
   );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates the single register-file write port between the ALU
// and a circular FIFO of returning loads. The ALU wins whenever it has a
// real request; loads drain when the ALU is idle. A starvation counter forces
// an ALU stall after STARVE_MAX consecutive ALU wins over a non-empty FIFO.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - wb_arbiter_if.slave (ALU request/stall, load request/ready,
//          registered write port WriteReg/DstReg/DstData, ld_pending mask)
module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STARVE_MAX = 3
) (
   input logic          clk,
   input logic          rst,
   wb_arbiter_if.slave  bus
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

   localparam logic [CntW-1:0] FullCnt   = CntW'(FIFO_DEPTH);
   localparam logic [StW-1:0]  StarveLim = StW'(STARVE_MAX);

   // Load FIFO storage; validity is tracked by the pointers and count alone
   logic [3:0]  fifo_reg  [FIFO_DEPTH];
   logic [15:0] fifo_data [FIFO_DEPTH];

   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [StW-1:0]  starve_q, starve_d;
   logic            alu_stall_q, alu_stall_d;
   logic            write_q, write_d;
   logic [3:0]      dst_reg_q, dst_reg_d;
   logic [15:0]     dst_data_q, dst_data_d;

   logic            full, empty, push, pop, alu_eff;
   logic [PtrW-1:0] idx;
   logic [15:0]     pending;

   always_comb begin
      full  = (count_q == FullCnt);
      empty = (count_q == '0);
      // Loads to r0 are accepted (ld_ready) but never enqueued
      push  = bus.ld_valid && !full && (bus.ld_reg != 4'd0);
      // alu_valid is ignored while stalled; r0 writes are not requests
      alu_eff = bus.alu_valid && !alu_stall_q && (bus.alu_reg != 4'd0);
      pop   = !alu_eff && !empty;

      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      starve_d    = starve_q;
      alu_stall_d = alu_stall_q;
      if (pop) begin
         starve_d    = '0;
         alu_stall_d = 1'b0;
      end else if (alu_eff && !empty) begin
         if (starve_q != StarveLim) starve_d = starve_q + StW'(1);
         if (starve_d == StarveLim) alu_stall_d = 1'b1;
      end

      // Unselected edges clear the enable but hold index/data
      write_d    = 1'b0;
      dst_reg_d  = dst_reg_q;
      dst_data_d = dst_data_q;
      if (alu_eff) begin
         write_d    = 1'b1;
         dst_reg_d  = bus.alu_reg;
         dst_data_d = bus.alu_data;
      end else if (pop) begin
         write_d    = 1'b1;
         dst_reg_d  = fifo_reg[rd_ptr_q];
         dst_data_d = fifo_data[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         alu_stall_q <= 1'b0;
         write_q     <= 1'b0;
         dst_reg_q   <= '0;
         dst_data_q  <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
         alu_stall_q <= alu_stall_d;
         write_q     <= write_d;
         dst_reg_q   <= dst_reg_d;
         dst_data_q  <= dst_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr_q]  <= bus.ld_reg;
         fifo_data[wr_ptr_q] <= bus.ld_data;
      end
   end

   // Mask of registers targeted by valid entries, walking from the head
   always_comb begin
      pending = '0;
      idx     = rd_ptr_q;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         idx = rd_ptr_q + PtrW'(i);
         if (CntW'(i) < count_q) pending[fifo_reg[idx]] = 1'b1;
      end
   end

   assign bus.ld_ready   = !full;
   assign bus.alu_stall  = alu_stall_q;
   assign bus.WriteReg   = write_q;
   assign bus.DstReg     = dst_reg_q;
   assign bus.DstData    = dst_data_q;
   assign bus.ld_pending = pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed-vector bench for wb_arbiter with hand-computed
// expectations. Inputs change 1 time unit after each rising edge; outputs are
// sampled at the same point, after the edge has settled.
module tb_wb_arbiter;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   wb_arbiter_if bus ();

   wb_arbiter #(
      .FIFO_DEPTH (4),
      .STARVE_MAX (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_alu(input logic v, input logic [3:0] r, input logic [15:0] d);
      bus.alu_valid = v;
      bus.alu_reg   = r;
      bus.alu_data  = d;
   endtask

   task automatic drive_ld(input logic v, input logic [3:0] r, input logic [15:0] d);
      bus.ld_valid = v;
      bus.ld_reg   = r;
      bus.ld_data  = d;
   endtask

   task automatic check_wr(input string tag, input logic w, input logic [3:0] r,
                           input logic [15:0] d);
      check({tag, "_we"}, 32'(bus.WriteReg), 32'(w));
      if (w) begin
         check({tag, "_reg"},  32'(bus.DstReg),  32'(r));
         check({tag, "_data"}, 32'(bus.DstData), 32'(d));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      drive_alu(1'b0, 4'd0, 16'h0);
      drive_ld(1'b0, 4'd0, 16'h0);
      #1;
      // Reset state
      check("rst_we",      32'(bus.WriteReg),   0);
      check("rst_reg",     32'(bus.DstReg),     0);
      check("rst_data",    32'(bus.DstData),    0);
      check("rst_stall",   32'(bus.alu_stall),  0);
      check("rst_ready",   32'(bus.ld_ready),   1);
      check("rst_pending", 32'(bus.ld_pending), 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_we", 32'(bus.WriteReg), 0);
      tick();

      // ALU only: 1-edge latency, then enable clears and data holds
      drive_alu(1'b1, 4'd5, 16'h1234);
      tick();
      check_wr("alu", 1'b1, 4'd5, 16'h1234);
      drive_alu(1'b0, 4'd0, 16'h0);
      tick();
      check("alu_idle_we",   32'(bus.WriteReg), 0);
      check("alu_idle_reg",  32'(bus.DstReg),   5);
      check("alu_idle_data", 32'(bus.DstData),  'h1234);

      // r0 drop on both paths
      drive_alu(1'b1, 4'd0, 16'hBEEF);
      drive_ld(1'b1, 4'd0, 16'hCAFE);
      #1;
      check("r0_ready", 32'(bus.ld_ready), 1);
      tick();
      check("r0_we",      32'(bus.WriteReg),   0);
      check("r0_pending", 32'(bus.ld_pending), 0);
      drive_alu(1'b0, 4'd0, 16'h0);
      drive_ld(1'b0, 4'd0, 16'h0);
      tick();
      check("r0_we2",      32'(bus.WriteReg),   0);
      check("r0_pending2", 32'(bus.ld_pending), 0);

      // FIFO fill under ALU pressure; stall after 3rd ALU win over non-empty FIFO
      drive_alu(1'b1, 4'd9, 16'hA009);
      for (int k = 1; k <= 4; k++) begin
         drive_ld(1'b1, 4'(k), 16'h1000 + 16'(k));
         tick();
         check_wr("fill_alu", 1'b1, 4'd9, 16'hA009);
         check("fill_stall", 32'(bus.alu_stall), (k == 4) ? 1 : 0);
         check("fill_ready", 32'(bus.ld_ready), (k == 4) ? 0 : 1);
      end
      check("fill_pending", 32'(bus.ld_pending), 'h001E);
      drive_ld(1'b0, 4'd0, 16'h0);
      tick();
      // Stalled: head pops, stall clears
      check_wr("pop1", 1'b1, 4'd1, 16'h1001);
      check("pop1_stall",   32'(bus.alu_stall),  0);
      check("pop1_pending", 32'(bus.ld_pending), 'h001C);
      check("pop1_ready",   32'(bus.ld_ready),   1);
      tick();
      // Held ALU request is taken once the stall drops
      check_wr("alu_resume", 1'b1, 4'd9, 16'hA009);
      check("resume_stall", 32'(bus.alu_stall), 0);
      drive_alu(1'b0, 4'd0, 16'h0);
      tick();
      check_wr("pop2", 1'b1, 4'd2, 16'h1002);
      check("pop2_pending", 32'(bus.ld_pending), 'h0018);
      tick();
      check_wr("pop3", 1'b1, 4'd3, 16'h1003);
      check("pop3_pending", 32'(bus.ld_pending), 'h0010);
      tick();
      check_wr("pop4", 1'b1, 4'd4, 16'h1004);
      check("pop4_pending", 32'(bus.ld_pending), 0);
      tick();
      check("drain_we", 32'(bus.WriteReg), 0);

      // Streamed loads across pointer wrap: push+pop each cycle keeps count at 1
      for (int k = 0; k < 6; k++) begin
         drive_ld(1'b1, 4'(10 + k), 16'hD0A0 + 16'(k));
         tick();
         check("wrap_pending", 32'(bus.ld_pending), 32'(1) << (10 + k));
         if (k == 0) check("wrap_first_we", 32'(bus.WriteReg), 0);
         else check_wr("wrap", 1'b1, 4'(9 + k), 16'hD0A0 + 16'(k - 1));
      end
      drive_ld(1'b0, 4'd0, 16'h0);
      tick();
      check_wr("wrap_last", 1'b1, 4'd15, 16'hD0A5);
      check("wrap_last_pending", 32'(bus.ld_pending), 0);
      tick();
      check("wrap_idle_we", 32'(bus.WriteReg), 0);

      // Async reset with 3 queued loads and a live write
      for (int k = 1; k <= 3; k++) begin
         drive_alu(1'b1, 4'd7, 16'h7776 + 16'(k));
         drive_ld(1'b1, 4'(k), 16'hE000 + 16'(k));
         tick();
      end
      check_wr("pre_rst", 1'b1, 4'd7, 16'h7779);
      check("pre_rst_pending", 32'(bus.ld_pending), 'h000E);
      check("pre_rst_stall",   32'(bus.alu_stall),  0);
      drive_alu(1'b0, 4'd0, 16'h0);
      drive_ld(1'b0, 4'd0, 16'h0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_we",      32'(bus.WriteReg),   0);
      check("arst_reg",     32'(bus.DstReg),     0);
      check("arst_data",    32'(bus.DstData),    0);
      check("arst_pending", 32'(bus.ld_pending), 0);
      check("arst_ready",   32'(bus.ld_ready),   1);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("arst_no_ghost", 32'(bus.WriteReg), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
